// File: rtl/mem_access_sequencer_if.sv
// mem_access_sequencer_if
//   Request/acknowledge bus between the data-memory access sequencer and
//   data memory.
//
//   mem_req    sequencer -> memory  access request, held until ack
//   mem_we     sequencer -> memory  1 = write, 0 = read
//   mem_addr   sequencer -> memory  access address
//   mem_wdata  sequencer -> memory  store data
//   mem_ack    memory -> sequencer  single-cycle completion pulse
//   mem_rdata  memory -> sequencer  read data, valid with mem_ack
//
//   modport master : sequencer side
//   modport slave  : memory side
interface mem_access_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Multi-cycle sequencer for MIPS data-memory accesses. Takes the decoded
//   load/store strobes and the ALU address, runs a req/ack handshake to data
//   memory and freezes the core with stall until the access retires.
//
//   Optional feature: define MEM_SEQ_TIMEOUT_EN to build a BUSY watchdog.
//   Without it, BUSY waits forever for mem_ack and timeout_err is tied 0.
//
//   Ports
//     clk          core clock
//     reset        synchronous, active-high
//     ld_en/st_en  instruction is a load / store (both set = store)
//     halted       core halted, blocks new accesses
//     addr, wdata  effective address and store data
//     stall        combinational pipeline freeze
//     rdata        last load result, rdata_valid pulses for one cycle
//     mem          memory bus (master modport)
//     loads_done   retired loads, wrapping
//     stores_done  retired stores, wrapping
//     timeout_err  sticky watchdog error
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for a load/store strobe
//   BUSY  | mem_req held, waiting for mem_ack
//   DONE  | access retired this cycle, rdata_valid for loads
//   ERR   | watchdog expired, stall held until reset (watchdog only)
module mem_access_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_en,
  input  logic                  st_en,
  input  logic                  halted,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  stall,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rdata_valid,
  mem_access_sequencer_if.master mem,
  output logic [CNT_W-1:0]      loads_done,
  output logic [CNT_W-1:0]      stores_done,
  output logic                  timeout_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              start;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic [CNT_W-1:0]  loads_q;
  logic [CNT_W-1:0]  stores_q;

`ifdef MEM_SEQ_TIMEOUT_EN
  // Down-counter loaded with TIMEOUT-1 on entry to BUSY; reaching zero in a
  // BUSY cycle without ack means TIMEOUT BUSY cycles have elapsed.
  localparam int             TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] tmr_q;
  logic             err_q;
  logic             tmr_expired;

  assign tmr_expired = (tmr_q == '0);
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  assign start = (ld_en | st_en) & ~halted;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_BUSY;
      S_BUSY: begin
        if (mem.mem_ack) state_d = S_DONE;
`ifdef MEM_SEQ_TIMEOUT_EN
        else if (tmr_expired) state_d = S_ERR;
`endif
      end
      S_DONE: state_d = S_IDLE;
`ifdef MEM_SEQ_TIMEOUT_EN
      S_ERR:  state_d = S_ERR;
`else
      S_ERR:  state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // DONE deliberately drops stall even if a strobe is present: the core
  // retires the access in that cycle, so no new access may start.
  assign stall = ((state_q == S_IDLE) && start) ||
                 (state_q == S_BUSY) ||
                 (state_q == S_ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      loads_q  <= '0;
      stores_q <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            req_q   <= 1'b1;
            we_q    <= st_en;
            addr_q  <= addr;
            wdata_q <= wdata;
          end
        end
        S_BUSY: begin
          if (mem.mem_ack) begin
            req_q <= 1'b0;
            if (we_q) begin
              stores_q <= stores_q + CNT_W'(1);
            end else begin
              rdata_q  <= mem.mem_rdata;
              rvalid_q <= 1'b1;
              loads_q  <= loads_q + CNT_W'(1);
            end
          end
`ifdef MEM_SEQ_TIMEOUT_EN
          else if (tmr_expired) begin
            req_q <= 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        tmr_q <= TMR_LOAD;
      end else if ((state_q == S_BUSY) && !mem.mem_ack) begin
        if (tmr_expired) begin
          err_q <= 1'b1;
        end else begin
          tmr_q <= tmr_q - TMR_W'(1);
        end
      end
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign rdata         = rdata_q;
  assign rdata_valid   = rvalid_q;
  assign loads_done    = loads_q;
  assign stores_done   = stores_q;

endmodule
